// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: holds the pipeline around a variable-latency data memory access,
// bubbles M/W while waiting, and tracks timeouts and total stall cycles.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread_m,
    input  logic              memwrite_m,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       readdata_m,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              bubble_w,
    output logic              timeout_err,
    output logic [PERF_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {IDLE, WAIT, RELEASE, ERROR} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [PERF_W-1:0] r_stall_cnt;
    logic              w_op;
    logic              w_stall;

    assign w_op    = memread_m | memwrite_m;
    // An access that misses in IDLE stalls in its very first cycle, before WAIT is reached
    assign w_stall = !reset & ((r_state == IDLE & w_op & !mem_ready) | r_state == WAIT | r_state == ERROR);
    assign mem_req = !reset & ((r_state == IDLE & w_op) | r_state == WAIT);
    assign mem_we  = mem_req & memwrite_m;
    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign stall_e = w_stall;
    assign stall_m = w_stall;
    assign bubble_w = w_stall;
    assign readdata_m = reset ? 32'd0 :
                        r_state == RELEASE ? r_rdata :
                        (r_state == IDLE & memread_m & !memwrite_m & mem_ready) ? mem_rdata : 32'd0;
    assign timeout_err  = r_err;
    assign stall_cycles = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            case (r_state)
                IDLE: if (w_op && !mem_ready) begin
                    r_state <= WAIT;
                    r_cnt   <= CNT_W'(1);
                end
                WAIT: if (mem_ready) begin
                    r_rdata <= mem_rdata;
                    r_state <= RELEASE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    r_state <= ERROR;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                RELEASE: r_state <= IDLE;
                ERROR: ;
            endcase
        end
    end
endmodule
